// File: rtl/mux_pkg.sv
// Shared constants for the 8:1 single-bit multiplexer.
package mux_pkg;

    localparam int unsigned DIN_W = 8;
    localparam int unsigned SEL_W = 3;

endpackage

// File: rtl/mux_81_mux21.sv
// 2:1 single-bit multiplexer cell; a is the lower-index input.
module mux21 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic out
);

    assign out = s ? b : a;

endmodule

// File: rtl/mux_81.sv
// Registered 8:1 single-bit multiplexer built as a three-level tree of mux21 cells.
module mux_81
    import mux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIN_W-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    logic [3:0] lvl0;
    logic [1:0] lvl1;
    logic       m;

    // Level 0: adjacent data pairs, steered by the select LSB
    for (genvar i = 0; i < 4; i++) begin : g_lvl0
        mux21 u_cell (
            .a   (din[2*i]),
            .b   (din[2*i+1]),
            .s   (sel[0]),
            .out (lvl0[i])
        );
    end

    // Level 1: pairs of level-0 results
    for (genvar i = 0; i < 2; i++) begin : g_lvl1
        mux21 u_cell (
            .a   (lvl0[2*i]),
            .b   (lvl0[2*i+1]),
            .s   (sel[1]),
            .out (lvl1[i])
        );
    end

    mux21 u_lvl2 (
        .a   (lvl1[0]),
        .b   (lvl1[1]),
        .s   (sel[2]),
        .out (m)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= 1'b0;
        end else begin
            y <= m;
        end
    end

endmodule

// File: tb/tb_mux_81.sv
// Self-checking bench for mux_81: vector table plus directed reset and timing sequences.
module tb_mux_81;

    typedef struct {
        logic [7:0] din;
        logic [2:0] sel;
        logic       exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [2:0] sel;
    logic       y;

    int n_vec;
    int n_err;

    vec_t vecs[$];

    mux_81 dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .sel (sel),
        .y   (y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: y=%b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs mid-cycle, then sample just after the next rising edge.
    task automatic apply(input logic [7:0] d, input logic [2:0] s, input logic exp, input string name);
        @(negedge clk);
        din = d;
        sel = s;
        @(posedge clk);
        #1;
        check(name, y, exp);
    endtask

    task automatic add(input logic [7:0] d, input logic [2:0] s, input logic e);
        vec_t v;
        v.din = d;
        v.sel = s;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] sw1_exp;
        logic [7:0] sw2_exp;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        din   = 8'hFF;
        sel   = 3'd7;

        // Sweep 1 / sweep 2 expected sequences, listed sel=0 first
        sw1_exp = 8'b1011_1101;
        sw2_exp = 8'b0110_0101;
        add(8'b1011_1101, 3'd0, 1'b1);
        add(8'b1011_1101, 3'd1, 1'b0);
        add(8'b1011_1101, 3'd2, 1'b1);
        add(8'b1011_1101, 3'd3, 1'b1);
        add(8'b1011_1101, 3'd4, 1'b1);
        add(8'b1011_1101, 3'd5, 1'b1);
        add(8'b1011_1101, 3'd6, 1'b0);
        add(8'b1011_1101, 3'd7, 1'b1);
        add(8'b0110_0101, 3'd0, 1'b1);
        add(8'b0110_0101, 3'd1, 1'b0);
        add(8'b0110_0101, 3'd2, 1'b1);
        add(8'b0110_0101, 3'd3, 1'b0);
        add(8'b0110_0101, 3'd4, 1'b0);
        add(8'b0110_0101, 3'd5, 1'b1);
        add(8'b0110_0101, 3'd6, 1'b1);
        add(8'b0110_0101, 3'd7, 1'b0);
        add(8'h08, 3'd3, 1'b1);
        add(8'h00, 3'd3, 1'b0);
        add(8'h08, 3'd3, 1'b1);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                add(8'(1 << k), 3'(j), (j == k) ? 1'b1 : 1'b0);
            end
        end

        // Asynchronous reset: y must clear before any clock edge
        #2 rst = 1'b1;
        #1 check("reset_async", y, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("reset_held", y, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_release_no_edge", y, 1'b0);
        @(posedge clk);
        #1 check("reset_release_first_edge", y, 1'b1);

        foreach (vecs[i]) begin
            apply(vecs[i].din, vecs[i].sel, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Mid-stream reset pulse between edges during sweep 1 at sel=4
        apply(8'b1011_1101, 3'd4, sw1_exp[4], "mid_pre");
        #1 rst = 1'b1;
        #1 check("mid_reset_async", y, 1'b0);
        #1 rst = 1'b0;
        #1 check("mid_reset_released_no_edge", y, 1'b0);
        @(posedge clk);
        #1 check("mid_reset_resume", y, sw1_exp[4]);

        // Glitching inputs between edges: only values at the edge matter
        @(negedge clk);
        din = 8'h00; sel = 3'd2;
        #1 din = 8'hFF; sel = 3'd5;
        #1 din = sw2_exp; sel = 3'd1;
        @(posedge clk);
        #1 check("glitch_filtered", y, 1'b0);

        // Simultaneous din and sel change uses both new values
        @(negedge clk);
        din = 8'h40; sel = 3'd6;
        @(posedge clk);
        #1 check("simultaneous_change", y, 1'b1);
        @(negedge clk);
        din = 8'hBF; sel = 3'd6;
        @(posedge clk);
        #1 check("simultaneous_change_0", y, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
